// File: rtl/ghash_n_blocks_mc.sv
// Multi-channel GHASH accumulator: folds up to N_BLOCKS 128-bit blocks per beat
// into one of N_CHANNELS independent running hashes, with a registered result on eop.
module ghash_n_blocks_mc #(
  parameter int NB_BLOCK   = 128,
  parameter int N_BLOCKS   = 2,
  parameter int NB_DATA    = N_BLOCKS * NB_BLOCK,
  parameter int N_CHANNELS = 4,
  parameter int NB_CHANNEL = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_data_x_bus,
  input  logic [NB_BLOCK-1:0]   i_data_x_initial,
  input  logic [NB_BLOCK-1:0]   i_hash_subkey_h,
  input  logic [NB_CHANNEL-1:0] i_channel,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_valid,
  input  logic [N_BLOCKS-1:0]   i_skip_bus,
  output logic [NB_BLOCK-1:0]   o_data_y,
  output logic [NB_CHANNEL-1:0] o_channel,
  output logic                  o_valid
);

  // Valid-only stream: a beat is consumed on every edge where i_valid=1 (no backpressure);
  // o_valid is a one-cycle strobe with o_data_y/o_channel holding between strobes.

  // GF(2^128) product in GCM bit-reflected order (bit NB_BLOCK-1 is the x^0 coefficient).
  function automatic logic [NB_BLOCK-1:0] gf_mul(input logic [NB_BLOCK-1:0] a,
                                                 input logic [NB_BLOCK-1:0] b);
    logic [NB_BLOCK-1:0] z;
    logic [NB_BLOCK-1:0] v;
    z = '0;
    v = b;
    for (int i = 0; i < NB_BLOCK; i++) begin
      if (a[NB_BLOCK-1-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, {(NB_BLOCK-8){1'b0}}};
      else      v = v >> 1;
    end
    return z;
  endfunction

  logic [NB_BLOCK-1:0]   r_acc [N_CHANNELS];
  logic [NB_BLOCK-1:0]   r_h   [N_CHANNELS];
  logic [NB_BLOCK-1:0]   r_data_y;
  logic [NB_CHANNEL-1:0] r_channel;
  logic                  r_valid;

  logic                  w_ch_ok;
  logic                  w_beat;
  logic [NB_BLOCK-1:0]   w_hc;
  logic [NB_BLOCK-1:0]   w_y [N_BLOCKS+1];

  assign w_ch_ok = {{(32-NB_CHANNEL){1'b0}}, i_channel} < 32'(N_CHANNELS);
  assign w_beat  = i_valid && w_ch_ok;

  // Out-of-range channels never reach the state update, so the read value is irrelevant.
  assign w_y[0] = i_sop ? i_data_x_initial : r_acc[i_channel];
  assign w_hc   = i_sop ? i_hash_subkey_h  : r_h[i_channel];

  for (genvar k = 0; k < N_BLOCKS; k++) begin : g_fold
    assign w_y[k+1] = i_skip_bus[k] ? w_y[k]
                    : gf_mul(w_y[k] ^ i_data_x_bus[k*NB_BLOCK +: NB_BLOCK], w_hc);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_h[c]   <= '0;
      end
      r_data_y  <= '0;
      r_channel <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_beat) begin
        r_acc[i_channel] <= w_y[N_BLOCKS];
        r_h[i_channel]   <= w_hc;
        if (i_eop) begin
          r_data_y  <= w_y[N_BLOCKS];
          r_channel <= i_channel;
          r_valid   <= 1'b1;
        end
      end
    end
  end

  assign o_data_y  = r_data_y;
  assign o_channel = r_channel;
  assign o_valid   = r_valid;

endmodule

// File: tb/tb_ghash_n_blocks_mc.sv
// Directed bench for ghash_n_blocks_mc: GCM test case 4 vectors, interleaving,
// skips, bubbles, reset and re-sop, plus an out-of-range channel on a 3-channel build.
module tb_ghash_n_blocks_mc;

  localparam logic [127:0] H_TC4 = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] Y_TC4 = 128'h698e57f70e6ecc7fd9463b7260a9ae5f;
  localparam logic [255:0] B1 = {128'habaddad2000000000000000000000000,
                                 128'hfeedfacedeadbeeffeedfacedeadbeef};
  localparam logic [255:0] B2 = {128'he3aa212f2c02a4e035c17e2329aca12e,
                                 128'h42831ec2217774244b7221b784d0d49c};
  localparam logic [255:0] B3 = {128'h1ba30b396a0aac973d58e09100000000,
                                 128'h21d514b25466931c7d8f6a5aac84aa05};
  localparam logic [255:0] B4 = {128'h0, 128'h00000000000000a000000000000001e0};
  localparam logic [127:0] ONE  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] INIT = 128'h0123456789abcdef0123456789abcdef;

  typedef struct {
    logic         rst;
    logic         vld;
    logic         sop;
    logic         eop;
    logic [1:0]   ch;
    logic [1:0]   skip;
    logic [255:0] x;
    logic [127:0] init;
    logic         exp_v;
    logic [1:0]   exp_ch;
    logic [127:0] exp_y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] x_bus;
  logic [127:0] x_init;
  logic [127:0] h_key;
  logic [1:0]   ch;
  logic         sop, eop, vld;
  logic [1:0]   skip;

  logic [127:0] y4, y3;
  logic [1:0]   ch4, ch3;
  logic         v4, v3;

  vec_t         tbl[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] last_y;
  logic [1:0]   last_ch;

  always #5 clk = ~clk;

  ghash_n_blocks_mc #(.N_BLOCKS(2), .N_CHANNELS(4)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_data_x_bus(x_bus), .i_data_x_initial(x_init),
    .i_hash_subkey_h(h_key), .i_channel(ch), .i_sop(sop), .i_eop(eop), .i_valid(vld),
    .i_skip_bus(skip), .o_data_y(y4), .o_channel(ch4), .o_valid(v4)
  );

  ghash_n_blocks_mc #(.N_BLOCKS(2), .N_CHANNELS(3)) u_dut3 (
    .i_clock(clk), .i_reset(rst), .i_data_x_bus(x_bus), .i_data_x_initial(x_init),
    .i_hash_subkey_h(h_key), .i_channel(ch), .i_sop(sop), .i_eop(eop), .i_valid(vld),
    .i_skip_bus(skip), .o_data_y(y3), .o_channel(ch3), .o_valid(v3)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic s, input logic e,
                     input logic [1:0] c, input logic [1:0] sk, input logic [255:0] x,
                     input logic [127:0] in, input logic ev, input logic [1:0] ec,
                     input logic [127:0] ey);
    vec_t t;
    t.rst = r; t.vld = v; t.sop = s; t.eop = e; t.ch = c; t.skip = sk; t.x = x;
    t.init = in; t.exp_v = ev; t.exp_ch = ec; t.exp_y = ey;
    tbl.push_back(t);
  endtask

  task automatic add_tc4(input logic [1:0] c);
    add(0, 1, 1, 0, c, 2'b00, B1, '0, 0, 0, '0);
    add(0, 1, 0, 0, c, 2'b00, B2, '0, 0, 0, '0);
    add(0, 1, 0, 0, c, 2'b00, B3, '0, 0, 0, '0);
    add(0, 1, 0, 1, c, 2'b10, B4, '0, 1, c, Y_TC4);
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic e,
                       input logic [1:0] c, input logic [1:0] sk, input logic [255:0] x,
                       input logic [127:0] in);
    rst = r; vld = v; sop = s; eop = e; ch = c; skip = sk; x_bus = x; x_init = in;
  endtask

  // One beat on the 3-channel instance, checked #1 after the capturing edge.
  task automatic beat3(input string name, input logic s, input logic e, input logic [1:0] c,
                       input logic [1:0] sk, input logic [255:0] x,
                       input logic ev, input logic [127:0] ey);
    @(negedge clk);
    drive(0, 1, s, e, c, sk, x, '0);
    @(posedge clk); #1;
    check({name, " o_valid"}, 128'(v3), 128'(ev));
    if (ev) begin
      check({name, " o_data_y"}, y3, ey);
      check({name, " o_channel"}, 128'(ch3), 128'(c));
    end
  endtask

  initial begin
    h_key = H_TC4;
    drive(1, 0, 0, 0, 0, 0, '0, '0);

    // reset, with a concurrent valid beat that must be ignored
    add(1, 1, 1, 1, 2'd0, 2'b00, B1, '0, 0, 0, '0);
    add_tc4(2'd0);
    // no auto-clear: eop with all blocks skipped returns the stored accumulator
    add(0, 1, 0, 1, 2'd0, 2'b11, B2, '0, 1, 2'd0, Y_TC4);
    // interleave channels 1 and 3
    add(0, 1, 1, 0, 2'd1, 2'b00, B1, '0, 0, 0, '0);
    add(0, 1, 1, 0, 2'd3, 2'b00, B1, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd1, 2'b00, B2, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd3, 2'b00, B2, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd1, 2'b00, B3, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd3, 2'b00, B3, '0, 0, 0, '0);
    add(0, 1, 0, 1, 2'd1, 2'b10, B4, '0, 1, 2'd1, Y_TC4);
    add(0, 1, 0, 1, 2'd3, 2'b10, B4, '0, 1, 2'd3, Y_TC4);
    // bubbles with garbage on the other inputs
    add(0, 1, 1, 0, 2'd2, 2'b00, B1, '0, 0, 0, '0);
    add(0, 0, 1, 1, 2'd2, 2'b00, B4, INIT, 0, 0, '0);
    add(0, 1, 0, 0, 2'd2, 2'b00, B2, '0, 0, 0, '0);
    add(0, 0, 0, 1, 2'd2, 2'b11, B3, INIT, 0, 0, '0);
    add(0, 0, 1, 0, 2'd0, 2'b01, B1, INIT, 0, 0, '0);
    add(0, 1, 0, 0, 2'd2, 2'b00, B3, '0, 0, 0, '0);
    add(0, 1, 0, 1, 2'd2, 2'b10, B4, '0, 1, 2'd2, Y_TC4);
    // single-beat packets: zero, all-skip seed, and 1*H through each block slot
    add(0, 1, 1, 1, 2'd0, 2'b00, '0, '0, 1, 2'd0, '0);
    add(0, 1, 1, 1, 2'd1, 2'b11, B1, INIT, 1, 2'd1, INIT);
    add(0, 1, 1, 1, 2'd2, 2'b10, {128'h0, ONE}, '0, 1, 2'd2, H_TC4);
    add(0, 1, 1, 1, 2'd3, 2'b01, {ONE, 128'h0}, '0, 1, 2'd3, H_TC4);
    add(0, 1, 1, 1, 2'd0, 2'b10, '0, ONE, 1, 2'd0, H_TC4);
    // re-sop discards the partial hash
    add(0, 1, 1, 0, 2'd0, 2'b00, B1, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd0, 2'b00, B2, '0, 0, 0, '0);
    add_tc4(2'd0);
    // reset mid-packet, racing a valid eop beat
    add(0, 1, 1, 0, 2'd3, 2'b00, B1, '0, 0, 0, '0);
    add(0, 1, 0, 0, 2'd3, 2'b00, B2, '0, 0, 0, '0);
    add(1, 1, 0, 1, 2'd3, 2'b00, B3, '0, 0, 0, '0);
    add_tc4(2'd3);

    last_y  = '0;
    last_ch = '0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].ch, tbl[i].skip,
            tbl[i].x, tbl[i].init);
      @(posedge clk); #1;
      if (tbl[i].rst) begin
        last_y  = '0;
        last_ch = '0;
      end else if (tbl[i].exp_v) begin
        last_y  = tbl[i].exp_y;
        last_ch = tbl[i].exp_ch;
      end
      check($sformatf("vec%0d o_valid", i), 128'(v4), 128'(tbl[i].exp_v));
      check($sformatf("vec%0d o_data_y", i), y4, last_y);
      check($sformatf("vec%0d o_channel", i), 128'(ch4), 128'(last_ch));
    end

    // 3-channel build: channel 3 is out of range and must be dropped silently
    beat3("c3 ch0 b1", 1, 0, 2'd0, 2'b00, B1, 0, '0);
    beat3("c3 ch1 b1", 1, 0, 2'd1, 2'b00, B1, 0, '0);
    beat3("c3 ch2 b1", 1, 0, 2'd2, 2'b00, B1, 0, '0);
    beat3("c3 oor sop", 1, 1, 2'd3, 2'b00, B4, 0, '0);
    beat3("c3 oor cont", 0, 1, 2'd3, 2'b11, B3, 0, '0);
    for (int c = 0; c < 3; c++) begin
      beat3($sformatf("c3 ch%0d b2", c), 0, 0, 2'(c), 2'b00, B2, 0, '0);
      beat3($sformatf("c3 ch%0d b3", c), 0, 0, 2'(c), 2'b00, B3, 0, '0);
      beat3($sformatf("c3 ch%0d b4", c), 0, 1, 2'(c), 2'b10, B4, 1, Y_TC4);
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    @(posedge clk); #1;
    check("idle o_valid", 128'(v4), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
